// File: rtl/systolic_pkg.sv
// Shared constants and types for the 3x3 systolic array driver.
package systolic_pkg;

  localparam int DW     = 8;
  localparam int LAST_T = 10;

  // Run cycle index at which each result element leaves the array
  localparam int T_C22 = 5;
  localparam int T_C21 = 6;
  localparam int T_C12 = 9;
  localparam int T_C11 = 10;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Counter width able to hold 0..last
  function automatic int t_width(input int last);
    return (last < 1) ? 1 : $clog2(last + 1);
  endfunction

endpackage

// File: rtl/systolic_feed_lane.sv
// One skewed operand lane: holds A1k/A2k and presents them on the lane
// at the run cycles assigned to lane K. The lane register is loaded from
// the next-cycle view of t/run so the output lines up with the cycle.
module systolic_feed_lane #(
  parameter int DW = 8,
  parameter int TW = 4,
  parameter int K  = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [DW-1:0] a_top,
  input  logic [DW-1:0] a_bot,
  input  logic          run_nxt,
  input  logic [TW-1:0] t_nxt,
  output logic [DW-1:0] left
);

  logic [DW-1:0] a1_q, a2_q, a1_n, a2_n;

  // Value the operand registers hold after this edge; t=0 of a fresh
  // run already needs the element being latched.
  always_comb begin
    a1_n = load ? a_top : a1_q;
    a2_n = load ? a_bot : a2_q;
  end

  // Operand latch and registered lane output
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a1_q <= '0;
      a2_q <= '0;
      left <= '0;
    end else begin
      a1_q <= a1_n;
      a2_q <= a2_n;
      if (!run_nxt)                 left <= '0;
      else if (t_nxt == TW'(K - 1)) left <= a2_n;
      else if (t_nxt == TW'(K + 3)) left <= a1_n;
      else                          left <= '0;
    end
  end

endmodule

// File: rtl/systolic_3by3_driver.sv
// Drives skewed A operands into a 3x3 systolic array and captures the
// four C elements as they emerge on array_out.
module systolic_3by3_driver #(
  parameter int DW     = systolic_pkg::DW,
  parameter int LAST_T = systolic_pkg::LAST_T
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] A11,
  input  logic [DW-1:0] A12,
  input  logic [DW-1:0] A13,
  input  logic [DW-1:0] A21,
  input  logic [DW-1:0] A22,
  input  logic [DW-1:0] A23,
  input  logic [DW-1:0] A31,
  input  logic [DW-1:0] A32,
  input  logic [DW-1:0] A33,
  input  logic [DW-1:0] array_out,
  output logic [DW-1:0] left1,
  output logic [DW-1:0] left2,
  output logic [DW-1:0] left3,
  output logic [DW-1:0] C11,
  output logic [DW-1:0] C12,
  output logic [DW-1:0] C21,
  output logic [DW-1:0] C22,
  output logic          busy,
  output logic          done
);
  import systolic_pkg::*;

  localparam int TW = t_width(LAST_T);

  state_t        state;
  logic [TW-1:0] t, t_nxt;
  logic          accept, run_nxt;

  logic [2:0][DW-1:0] a_top, a_bot, lanes;

  // Row 3 of A never reaches the lanes that feed the 2x2 result
  logic unused_row3;
  assign unused_row3 = ^{A31, A32, A33};

  assign a_top = {A13, A12, A11};
  assign a_bot = {A23, A22, A21};
  assign left1 = lanes[0];
  assign left2 = lanes[1];
  assign left3 = lanes[2];

  // Next-cycle run state seen by the lanes; start only counts in IDLE/DONE
  always_comb begin
    accept  = start && (state == IDLE || state == DONE);
    run_nxt = accept || (state == RUN && t != TW'(LAST_T));
    t_nxt   = accept ? '0 : t + 1'b1;
  end

  genvar k;
  generate
    for (k = 0; k < 3; k++) begin : g_lane
      systolic_feed_lane #(.DW(DW), .TW(TW), .K(k + 1)) u_lane (
        .clk     (clk),
        .rst     (rst),
        .load    (accept),
        .a_top   (a_top[k]),
        .a_bot   (a_bot[k]),
        .run_nxt (run_nxt),
        .t_nxt   (t_nxt),
        .left    (lanes[k])
      );
    end
  endgenerate

  // Run FSM with registered busy/done, cycle counter and result capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      t     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      C11   <= '0;
      C12   <= '0;
      C21   <= '0;
      C22   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (accept) begin
            state <= RUN;
            busy  <= 1'b1;
            t     <= '0;
            C11   <= '0;
            C12   <= '0;
            C21   <= '0;
            C22   <= '0;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          t <= t + 1'b1;
          if (t == TW'(T_C22)) C22 <= array_out;
          if (t == TW'(T_C21)) C21 <= array_out;
          if (t == TW'(T_C12)) C12 <= array_out;
          if (t == TW'(T_C11)) C11 <= array_out;
          if (t == TW'(LAST_T)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_3by3_driver.sv
// Scoreboard bench: launches push expected lane triples and C results,
// a negedge monitor pops them whenever busy/done are presented.
module tb_systolic_3by3_driver;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic [8:0][7:0] a_vec = '0;
  logic [7:0]      array_out = '0;
  logic [7:0]      left1, left2, left3, C11, C12, C21, C22;
  logic            busy, done;

  int          tests = 0, fails = 0, done_seen = 0;
  int          cyc = 0;
  int          done_cyc[$];
  logic [23:0] lane_q[$];
  logic [31:0] c_q[$];

  systolic_3by3_driver #(.DW(8), .LAST_T(10)) dut (
    .clk(clk), .rst(rst), .start(start),
    .A11(a_vec[0]), .A12(a_vec[1]), .A13(a_vec[2]),
    .A21(a_vec[3]), .A22(a_vec[4]), .A23(a_vec[5]),
    .A31(a_vec[6]), .A32(a_vec[7]), .A33(a_vec[8]),
    .array_out(array_out),
    .left1(left1), .left2(left2), .left3(left3),
    .C11(C11), .C12(C12), .C21(C21), .C22(C22),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: lanes checked every cycle, C results on each done pulse
  always @(negedge clk) begin
    if (rst) begin
      if (busy) begin
        if (lane_q.size() == 0) chk("unexpected_busy", 32'(busy), 32'h0);
        else chk("lanes", {8'h0, left1, left2, left3}, {8'h0, lane_q.pop_front()});
      end else begin
        chk("idle_lanes", {8'h0, left1, left2, left3}, 32'h0);
      end
      if (done) begin
        done_seen++;
        done_cyc.push_back(cyc);
        chk("busy_in_done", 32'(busy), 32'h0);
        if (c_q.size() == 0) chk("unexpected_done", 32'(done), 32'h0);
        else chk("c_result", {C11, C12, C21, C22}, c_q.pop_front());
      end
    end
  end

  // Request a run; start is sampled at the next rising edge
  task automatic launch(input logic [8:0][7:0] a, input logic [31:0] c);
    logic [7:0] l [3];
    @(negedge clk);
    a_vec = a;
    start = 1'b1;
    for (int t = 0; t <= 10; t++) begin
      for (int k = 1; k <= 3; k++)
        l[k-1] = (t == k - 1) ? a[k+2] : (t == k + 3) ? a[k-1] : 8'h0;
      lane_q.push_back({l[0], l[1], l[2]});
    end
    c_q.push_back(c);
  endtask

  // Drive array_out = base+t over the run; optional FF at t=5, a stray
  // start with new A at ign_t, or a reset at rst_t
  task automatic feed(input logic [7:0] base, input bit wrap5, input int ign_t, input int rst_t);
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i == 0) chk("c_cleared", {C11, C12, C21, C22}, 32'h0);
      array_out = (wrap5 && i == 5) ? 8'hFF : base + 8'(i);
      if (i == ign_t) begin
        start = 1'b1;
        a_vec = ~a_vec;
      end
      if (i == rst_t) begin
        #2 rst = 1'b0;
        #1;
        chk("async_rst_lanes", {8'h0, left1, left2, left3}, 32'h0);
        chk("async_rst_c", {C11, C12, C21, C22}, 32'h0);
        chk("async_rst_flags", {30'h0, busy, done}, 32'h0);
        lane_q.delete();
        c_q.delete();
        return;
      end
    end
  endtask

  initial begin
    int d0;
    repeat (2) @(negedge clk);
    chk("reset_lanes", {8'h0, left1, left2, left3}, 32'h0);
    chk("reset_c", {C11, C12, C21, C22}, 32'h0);
    chk("reset_flags", {30'h0, busy, done}, 32'h0);
    #2 rst = 1'b1;

    // Basic feed and capture, A = 1..9
    launch({8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 32'h1A191615);
    feed(8'h10, 1'b0, -1, -1);
    repeat (3) @(negedge clk);

    // Wrap value captured unmodified at t=5
    launch({8'h99, 8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11}, 32'h2A2926FF);
    feed(8'h20, 1'b1, -1, -1);
    repeat (2) @(negedge clk);

    // Start during RUN with new A is ignored
    launch({8'hC9, 8'hC8, 8'hC7, 8'hC6, 8'hC5, 8'hC4, 8'hC3, 8'hC2, 8'hC1}, 32'h3A393635);
    feed(8'h30, 1'b0, 3, -1);
    repeat (3) @(negedge clk);

    // Back-to-back runs via start in DONE; second run wraps mod 256
    launch({8'h29, 8'h28, 8'h27, 8'h26, 8'h25, 8'h24, 8'h23, 8'h22, 8'h21}, 32'h5A595655);
    feed(8'h50, 1'b0, -1, -1);
    launch({8'h39, 8'h38, 8'h37, 8'h36, 8'h35, 8'h34, 8'h33, 8'h32, 8'h31}, 32'h0201FEFD);
    feed(8'hF8, 1'b0, -1, -1);
    @(negedge clk);
    #1;
    if (done_cyc.size() >= 2) chk("b2b_gap", 32'(done_cyc[$] - done_cyc[$-1]), 32'd12);
    else chk("b2b_done_count", 32'(done_cyc.size()), 32'd2);
    repeat (2) @(negedge clk);

    // Reset mid-run at t=4: no done afterwards
    d0 = done_seen;
    launch({8'h49, 8'h48, 8'h47, 8'h46, 8'h45, 8'h44, 8'h43, 8'h42, 8'h41}, 32'h0);
    feed(8'h00, 1'b0, -1, 4);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    repeat (15) @(negedge clk);
    chk("no_done_after_rst", 32'(done_seen), 32'(d0));

    // Fresh run after reset release
    launch({8'hE9, 8'hE8, 8'hE7, 8'hE6, 8'hE5, 8'hE4, 8'hE3, 8'hE2, 8'hE1}, 32'h0A090605);
    feed(8'h00, 1'b0, -1, -1);
    repeat (3) @(negedge clk);

    chk("lane_q_drained", 32'(lane_q.size()), 32'd0);
    chk("c_q_drained", 32'(c_q.size()), 32'd0);
    chk("done_total", 32'(done_seen), 32'd6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
